// File: rtl/pkt_matrix_arbiter_pkg.sv
// Shared types and helpers for the packet-aware matrix arbiter.
package noc2_arb_pkg;

  typedef enum logic [0:0] {ARB_IDLE, ARB_LOCKED} arb_state_t;

  localparam int ARB_NUM_DEFAULT       = 4;
  localparam int ARB_MAX_BEATS_DEFAULT = 64;
  // Widest requester vector the index helper accepts.
  localparam int ARB_NUM_MAX           = 64;

  // Binary index of a one-hot vector; only the low num bits are considered.
  function automatic int onehot_to_idx(input logic [ARB_NUM_MAX-1:0] oh, input int num);
    int idx;
    idx = 0;
    for (int k = 0; k < ARB_NUM_MAX; k++) begin
      if (k < num && oh[k]) idx = idx | k;
    end
    return idx;
  endfunction

endpackage

// File: rtl/pkt_matrix_arbiter_if.sv
// Request/grant bundle between input-VC heads and the arbiter.
interface pkt_matrix_arbiter_if
  import noc2_arb_pkg::*;
#(
  parameter int NUM   = ARB_NUM_DEFAULT,
  parameter int IDX_W = $clog2(NUM)
);
  logic [NUM-1:0]   i_req;
  logic [NUM-1:0]   i_last;
  logic             i_accept;
  logic [NUM-1:0]   o_gnt;
  logic [IDX_W-1:0] o_gnt_idx;
  logic             o_locked;
  logic             o_overrun;

  modport master (
    output i_req, i_last, i_accept,
    input  o_gnt, o_gnt_idx, o_locked, o_overrun
  );

  modport slave (
    input  i_req, i_last, i_accept,
    output o_gnt, o_gnt_idx, o_locked, o_overrun
  );
endinterface

// File: rtl/pkt_matrix_arbiter_core.sv
// Least-recently-served priority matrix: upper-triangle flops, mirrored lower half.
module matrix_prio_core
  import noc2_arb_pkg::*;
#(
  parameter int NUM = ARB_NUM_DEFAULT
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [NUM-1:0] req_eff,
  input  logic           upd,
  input  logic [NUM-1:0] upd_onehot,
  output logic [NUM-1:0] arb_gnt
);

  // m[i][j] = 1 means requester i beats requester j.
  logic [NUM-1:0][NUM-1:0] m;
  logic [NUM-1:0]          dis;

  for (genvar gi = 0; gi < NUM; gi++) begin : g_row
    assign m[gi][gi] = 1'b0;
    for (genvar gj = gi + 1; gj < NUM; gj++) begin : g_col
      logic p_q, p_d;

      // Winner drops below everyone it shares a cell with.
      always_comb begin
        p_d = p_q;
        if (upd) p_d = (p_q | upd_onehot[gj]) & ~upd_onehot[gi];
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) p_q <= 1'b0;
        else     p_q <= p_d;
      end

      assign m[gi][gj] = p_q;
      assign m[gj][gi] = ~p_q;
    end
  end

  always_comb begin
    dis = '0;
    for (int j = 0; j < NUM; j++) begin
      for (int i = 0; i < NUM; i++) begin
        dis[j] = dis[j] | (m[i][j] & req_eff[i]);
      end
    end
  end

  assign arb_gnt = req_eff & ~dis;

endmodule

// File: rtl/pkt_matrix_arbiter.sv
// Packet-locking LRS arbiter for one NoC router output port, with beat watchdog.
module pkt_matrix_arbiter
  import noc2_arb_pkg::*;
#(
  parameter int NUM       = ARB_NUM_DEFAULT,
  parameter int LOCK_PKT  = 1,
  parameter int MAX_BEATS = ARB_MAX_BEATS_DEFAULT,
  parameter int IDX_W     = $clog2(NUM)
) (
  input  logic                clk,
  input  logic                rst,
  pkt_matrix_arbiter_if.slave bus
);

  localparam int CNT_W = $clog2(MAX_BEATS + 1);

  arb_state_t       state_q, state_d;
  logic [IDX_W-1:0] lock_idx_q, lock_idx_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic             overrun_q, overrun_d;

  logic [NUM-1:0]   lock_oh;
  logic [NUM-1:0]   req_eff;
  logic [NUM-1:0]   arb_gnt;
  logic [IDX_W-1:0] win_idx;
  logic             xfer;
  logic             win_last;
  logic             upd;

  matrix_prio_core #(.NUM(NUM)) u_core (
    .clk        (clk),
    .rst        (rst),
    .req_eff    (req_eff),
    .upd        (upd),
    .upd_onehot (arb_gnt),
    .arb_gnt    (arb_gnt)
  );

  // While locked only the owner may compete, so the matrix grants it or nothing.
  always_comb begin
    lock_oh = {{(NUM-1){1'b0}}, 1'b1} << lock_idx_q;
    req_eff = bus.i_req;
    if (state_q == ARB_LOCKED) req_eff = bus.i_req & lock_oh;
  end

  always_comb begin
    win_idx  = IDX_W'(onehot_to_idx(ARB_NUM_MAX'(arb_gnt), NUM));
    xfer     = (|(arb_gnt & bus.i_req)) & bus.i_accept;
    win_last = |(arb_gnt & bus.i_last);
  end

  always_comb begin
    state_d    = state_q;
    lock_idx_d = lock_idx_q;
    beat_cnt_d = beat_cnt_q;
    overrun_d  = overrun_q;
    upd        = 1'b0;
    if (LOCK_PKT == 0) begin
      state_d = ARB_IDLE;
      upd     = xfer;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (xfer) begin
            if (win_last) begin
              upd = 1'b1;
            end else begin
              state_d    = ARB_LOCKED;
              lock_idx_d = win_idx;
              beat_cnt_d = CNT_W'(1);
            end
          end
        end
        ARB_LOCKED: begin
          if (xfer) begin
            if (win_last) begin
              upd        = 1'b1;
              state_d    = ARB_IDLE;
              beat_cnt_d = '0;
            end else if (beat_cnt_q == CNT_W'(MAX_BEATS - 1)) begin
              // Runaway packet: release and demote the owner anyway.
              upd        = 1'b1;
              state_d    = ARB_IDLE;
              beat_cnt_d = '0;
              overrun_d  = 1'b1;
            end else begin
              beat_cnt_d = beat_cnt_q + CNT_W'(1);
            end
          end
        end
        default: state_d = ARB_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ARB_IDLE;
      lock_idx_q <= '0;
      beat_cnt_q <= '0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      lock_idx_q <= lock_idx_d;
      beat_cnt_q <= beat_cnt_d;
      overrun_q  <= overrun_d;
    end
  end

  assign bus.o_gnt     = arb_gnt;
  assign bus.o_gnt_idx = win_idx;
  assign bus.o_locked  = (state_q == ARB_LOCKED);
  assign bus.o_overrun = overrun_q;

endmodule

// File: tb/tb_pkt_matrix_arbiter.sv
// Scoreboard bench: a packet-locking instance (MAX_BEATS=4) and a per-beat instance share stimulus.
module tb_pkt_matrix_arbiter;

  localparam int NUM  = 4;
  localparam int MAXB = 4;

  logic clk;
  logic rst;
  logic [NUM-1:0] req, last;
  logic acc;

  pkt_matrix_arbiter_if #(.NUM(NUM)) if_a ();
  pkt_matrix_arbiter_if #(.NUM(NUM)) if_b ();

  assign if_a.i_req    = req;
  assign if_a.i_last   = last;
  assign if_a.i_accept = acc;
  assign if_b.i_req    = req;
  assign if_b.i_last   = last;
  assign if_b.i_accept = acc;

  pkt_matrix_arbiter #(.NUM(NUM), .LOCK_PKT(1), .MAX_BEATS(MAXB)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (if_a)
  );

  pkt_matrix_arbiter #(.NUM(NUM), .LOCK_PKT(0), .MAX_BEATS(MAXB)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (if_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int       cyc;
    logic [3:0] gnt_a;
    logic [1:0] idx_a;
    logic       lk_a;
    logic       ov_a;
    logic [3:0] gnt_b;
    logic [1:0] idx_b;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference: priority is a list, most-favoured first; a served requester moves to the end.
  int ord_a[$];
  int ord_b[$];
  bit lk_a;
  int own_a;
  int beats_a;
  bit ovr_a;

  function automatic int first_req(input int ord[$], input logic [3:0] r);
    for (int k = 0; k < ord.size(); k++) begin
      if (r[ord[k]]) return ord[k];
    end
    return -1;
  endfunction

  task automatic demote_a(input int w);
    for (int k = 0; k < ord_a.size(); k++) begin
      if (ord_a[k] == w) begin
        ord_a.delete(k);
        break;
      end
    end
    ord_a.push_back(w);
  endtask

  task automatic demote_b(input int w);
    for (int k = 0; k < ord_b.size(); k++) begin
      if (ord_b[k] == w) begin
        ord_b.delete(k);
        break;
      end
    end
    ord_b.push_back(w);
  endtask

  task automatic model_reset();
    ord_a = {3, 2, 1, 0};
    ord_b = {3, 2, 1, 0};
    lk_a = 1'b0;
    own_a = 0;
    beats_a = 0;
    ovr_a = 1'b0;
  endtask

  task automatic step(input logic [3:0] r, input logic [3:0] l, input logic a, input logic do_rst);
    exp_t e;
    int wa, wb;
    @(posedge clk);
    #1;
    rst  = do_rst;
    req  = r;
    last = l;
    acc  = a;
    if (do_rst) model_reset();
    if (lk_a) wa = r[own_a] ? own_a : -1;
    else      wa = first_req(ord_a, r);
    wb = first_req(ord_b, r);
    e.cyc   = cyc;
    e.gnt_a = (wa >= 0) ? 4'(1 << wa) : 4'b0;
    e.idx_a = (wa >= 0) ? 2'(wa) : 2'd0;
    e.lk_a  = lk_a;
    e.ov_a  = ovr_a;
    e.gnt_b = (wb >= 0) ? 4'(1 << wb) : 4'b0;
    e.idx_b = (wb >= 0) ? 2'(wb) : 2'd0;
    sb.push_back(e);
    if (!do_rst && a && wa >= 0) begin
      if (!lk_a) begin
        if (l[wa]) demote_a(wa);
        else begin
          lk_a = 1'b1;
          own_a = wa;
          beats_a = 1;
        end
      end else if (l[wa]) begin
        lk_a = 1'b0;
        demote_a(wa);
      end else if (beats_a + 1 == MAXB) begin
        lk_a = 1'b0;
        ovr_a = 1'b1;
        demote_a(wa);
      end else begin
        beats_a++;
      end
    end
    if (!do_rst && a && wb >= 0) demote_b(wb);
    cyc++;
  endtask

  task automatic chk(input string name, input int c, input logic [7:0] act, input logic [7:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, c, act, exp_v);
    end
  endtask

  // Monitor: compares mid-cycle, away from the active edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        $display("cyc=%0d rst=%b req=%b last=%b acc=%b | A gnt=%b lk=%b ov=%b | B gnt=%b",
                 e.cyc, rst, req, last, acc, if_a.o_gnt, if_a.o_locked, if_a.o_overrun, if_b.o_gnt);
        chk("a_gnt",     e.cyc, 8'(if_a.o_gnt),     8'(e.gnt_a));
        chk("a_idx",     e.cyc, 8'(if_a.o_gnt_idx), 8'(e.idx_a));
        chk("a_locked",  e.cyc, 8'(if_a.o_locked),  8'(e.lk_a));
        chk("a_overrun", e.cyc, 8'(if_a.o_overrun), 8'(e.ov_a));
        chk("b_gnt",     e.cyc, 8'(if_b.o_gnt),     8'(e.gnt_b));
        chk("b_idx",     e.cyc, 8'(if_b.o_gnt_idx), 8'(e.idx_b));
        chk("b_locked",  e.cyc, 8'(if_b.o_locked),  8'd0);
        chk("b_overrun", e.cyc, 8'(if_b.o_overrun), 8'd0);
      end
    end
  end

  initial begin
    rst  = 1'b1;
    req  = '0;
    last = '0;
    acc  = 1'b0;
    model_reset();
    // Reset state: requester 3 favoured, nothing locked.
    step(4'b1111, 4'b1111, 1'b1, 1'b1);
    step(4'b1111, 4'b1111, 1'b1, 1'b1);
    // Single-beat packets from everyone: grants rotate 3,2,1,0,3.
    for (int k = 0; k < 5; k++) step(4'b1111, 4'b1111, 1'b1, 1'b0);
    // Three-beat packet while a competitor waits; then the competitor.
    step(4'b0110, 4'b0000, 1'b1, 1'b0);
    step(4'b0110, 4'b0000, 1'b1, 1'b0);
    step(4'b0110, 4'b0110, 1'b1, 1'b0);
    step(4'b0110, 4'b0110, 1'b1, 1'b0);
    // Owner 0 locks, then drops its request with accept toggling.
    step(4'b0001, 4'b0000, 1'b1, 1'b0);
    step(4'b1110, 4'b0000, 1'b1, 1'b0);
    step(4'b1110, 4'b0000, 1'b0, 1'b0);
    step(4'b1111, 4'b0000, 1'b0, 1'b0);
    step(4'b1111, 4'b0000, 1'b1, 1'b0);
    step(4'b1111, 4'b0001, 1'b1, 1'b0);
    // Owner never sends a tail: watchdog must release after MAXB transfers.
    for (int k = 0; k < 6; k++) step(4'b1001, 4'b0000, 1'b1, 1'b0);
    // Two non-tail requesters; the per-beat instance alternates.
    for (int k = 0; k < 4; k++) step(4'b0101, 4'b0000, 1'b1, 1'b0);
    // Reset pulse in the middle of a packet.
    step(4'b0100, 4'b0000, 1'b1, 1'b0);
    step(4'b0100, 4'b0000, 1'b1, 1'b0);
    step(4'b1111, 4'b0000, 1'b1, 1'b1);
    step(4'b1111, 4'b1111, 1'b1, 1'b0);
    step(4'b1111, 4'b1111, 1'b1, 1'b0);
    // Randomized traffic with occasional resets.
    for (int k = 0; k < 500; k++) begin
      logic [3:0] r, l;
      logic a, d;
      r = 4'($urandom_range(0, 15));
      for (int b = 0; b < NUM; b++) l[b] = ($urandom_range(0, 3) == 0);
      a = ($urandom_range(0, 3) != 0);
      d = ($urandom_range(0, 199) == 0);
      step(r, l, a, d);
    end
    @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
